intersection_ctrl: RTL and testbench

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_ctrl.sv | 179 +++++++++++++++++
 tb/tb_intersection_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/intersection_ctrl.sv
// Two-phase traffic intersection controller with pedestrian service.
// A single state register drives all lamps as a Moore decode. One shared
// down-counter times every dwell: it loads (dwell-1) on state entry and the
// state is left on an enabled cycle that finds it at zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// INIT   | all-red start-up clearance after reset
// NS_G   | north-south green; rests here until a cross or ped request
// NS_Y   | north-south yellow
// NS_CLR | all-red clearance after NS; chooses PED_A or EW_G
// PED_A  | pedestrian walk between NS and EW phases
// EW_G   | east-west green; rests here until a cross or ped request
// EW_Y   | east-west yellow
// EW_CLR | all-red clearance after EW; chooses PED_B or NS_G
// PED_B  | pedestrian walk between EW and NS phases
module intersection_ctrl #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic       walk,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        NS_G   = 4'd1,
        NS_Y   = 4'd2,
        NS_CLR = 4'd3,
        PED_A  = 4'd4,
        EW_G   = 4'd5,
        EW_Y   = 4'd6,
        EW_CLR = 4'd7,
        PED_B  = 4'd8
    } state_t;

    // Timer load values are dwell-1 so that a dwell of N spans N enabled cycles.
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           state_q;
    state_t           state_d;
    state_t           target;
    logic             legal;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic             ped_pend_q;
    logic             ped_pend_d;
    logic             in_ped_q;
    logic             in_ped_d;

    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        logic [CNT_W-1:0] ld;
        case (s)
            NS_G, EW_G:   ld = LD_GREEN;
            NS_Y, EW_Y:   ld = LD_YELLOW;
            PED_A, PED_B: ld = LD_WALK;
            default:      ld = LD_ALLRED;
        endcase
        return ld;
    endfunction

    // State, timer and pending-pedestrian registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            timer_q    <= LD_ALLRED;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    // Where each state would go once its dwell has expired.
    always_comb begin
        target = state_q;
        legal  = 1'b1;
        case (state_q)
            INIT:    target = NS_G;
            NS_G:    target = (req_ew || ped_pend_q) ? NS_Y : NS_G;
            NS_Y:    target = NS_CLR;
            NS_CLR:  target = ped_pend_q ? PED_A : EW_G;
            PED_A:   target = EW_G;
            EW_G:    target = (req_ns || ped_pend_q) ? EW_Y : EW_G;
            EW_Y:    target = EW_CLR;
            EW_CLR:  target = ped_pend_q ? PED_B : NS_G;
            PED_B:   target = NS_G;
            default: begin
                target = INIT;
                legal  = 1'b0;
            end
        endcase
    end

    // Timer countdown and state advance; an unused encoding recovers at once,
    // even while en is low, so a corrupted register cannot stall the lamps.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!legal) begin
            state_d = INIT;
            timer_d = LD_ALLRED;
        end else if (en) begin
            if (timer_q != CNT_ZERO) begin
                timer_d = timer_q - CNT_ONE;
            end else if (target != state_q) begin
                state_d = target;
                timer_d = load_for(target);
            end
        end
    end

    // Pedestrian request latch. It is forced low while a walk phase is
    // current or about to start, so presses during a walk are absorbed by it.
    // The CLR decision reads the registered value, so a press on the exit
    // cycle itself waits for the following clearance.
    always_comb begin
        in_ped_q   = (state_q == PED_A) || (state_q == PED_B);
        in_ped_d   = (state_d == PED_A) || (state_d == PED_B);
        ped_pend_d = ped_pend_q | ped_req;
        if (in_ped_q || in_ped_d) begin
            ped_pend_d = 1'b0;
        end
    end

    // Moore lamp decode; anything not a go/caution state is all red.
    always_comb begin
        ns_r  = 1'b1;
        ns_y  = 1'b0;
        ns_g  = 1'b0;
        ew_r  = 1'b1;
        ew_y  = 1'b0;
        ew_g  = 1'b0;
        walk  = 1'b0;
        phase = state_q;
        case (state_q)
            NS_G: begin
                ns_r = 1'b0;
                ns_g = 1'b1;
            end
            NS_Y: begin
                ns_r = 1'b0;
                ns_y = 1'b1;
            end
            EW_G: begin
                ew_r = 1'b0;
                ew_g = 1'b1;
            end
            EW_Y: begin
                ew_r = 1'b0;
                ew_y = 1'b1;
            end
            PED_A, PED_B: walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl: a table of per-cycle vectors with
// expected phase, followed by hand-written pedestrian corner sequences.
module tb_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       req_ns = 1'b0;
    logic       req_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk;
    logic [3:0] phase;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rns;
        logic       rew;
        logic       ped;
        logic [3:0] ph;
    } vec_t;

    vec_t vecs[$];

    intersection_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req_ns (req_ns),
        .req_ew (req_ew),
        .ped_req(ped_req),
        .ns_r   (ns_r),
        .ns_y   (ns_y),
        .ns_g   (ns_g),
        .ew_r   (ew_r),
        .ew_y   (ew_y),
        .ew_g   (ew_g),
        .walk   (walk),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Expected {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for a given phase.
    function automatic logic [6:0] lamps_of(input logic [3:0] p);
        case (p)
            4'd1:       return 7'b0011000;
            4'd2:       return 7'b0101000;
            4'd5:       return 7'b1000010;
            4'd6:       return 7'b1000100;
            4'd4, 4'd8: return 7'b1001001;
            default:    return 7'b1001000;
        endcase
    endfunction

    function automatic void add(input int n, input logic r, input logic e,
                                input logic rns, input logic rew,
                                input logic ped, input logic [3:0] ph);
        vec_t v;
        v.rst = r; v.en = e; v.rns = rns; v.rew = rew; v.ped = ped; v.ph = ph;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check_out(input string name, input logic [3:0] exp_ph);
        logic [6:0] act_l;
        logic       inv_ok;
        act_l = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};
        total_cnt++;
        if (phase === exp_ph) pass_cnt++;
        else $display("FAIL %s phase: got %0d expected %0d", name, phase, exp_ph);
        total_cnt++;
        if (act_l === lamps_of(exp_ph)) pass_cnt++;
        else $display("FAIL %s lamps: got %b expected %b", name, act_l, lamps_of(exp_ph));
        inv_ok = ($countones({ns_r, ns_y, ns_g}) == 1) &&
                 ($countones({ew_r, ew_y, ew_g}) == 1) &&
                 !(ns_g && ew_g) && (!walk || (ns_r && ew_r));
        total_cnt++;
        if (inv_ok) pass_cnt++;
        else $display("FAIL %s lamp_invariant: got %b expected legal lamp set", name, act_l);
    endtask

    task automatic step_chk(input string name, input logic [3:0] exp_ph);
        @(posedge clk);
        #1;
        check_out(name, exp_ph);
    endtask

    task automatic run_until(input string name, input logic [3:0] p, input int budget);
        int n;
        n = 0;
        while (phase !== p && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total_cnt++;
        if (phase === p) pass_cnt++;
        else $display("FAIL %s wait: got phase %0d expected %0d within %0d cycles", name, phase, p, budget);
    endtask

    initial begin
        // reset then idle: two all-red cycles, then NS green resting
        add(2, 1, 1, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 0, 0, 4'd1);
        add(20, 0, 1, 0, 0, 0, 4'd1);
        // single-cycle EW request after long rest; then en=0 freeze in NS_Y
        add(1, 0, 1, 0, 1, 0, 4'd2);
        add(5, 0, 0, 0, 0, 0, 4'd2);
        add(2, 0, 1, 0, 0, 0, 4'd2);
        add(2, 0, 1, 0, 0, 0, 4'd3);
        add(1, 0, 1, 0, 0, 0, 4'd5);
        add(10, 0, 1, 0, 0, 0, 4'd5);
        add(1, 0, 1, 1, 0, 0, 4'd6);
        add(2, 0, 1, 0, 0, 0, 4'd6);
        add(2, 0, 1, 0, 0, 0, 4'd7);
        add(1, 0, 1, 0, 0, 0, 4'd1);
        // pedestrian press in NS_G cycle 3
        add(2, 0, 1, 0, 0, 0, 4'd1);
        add(1, 0, 1, 0, 0, 1, 4'd1);
        add(4, 0, 1, 0, 0, 0, 4'd1);
        add(3, 0, 1, 0, 0, 0, 4'd2);
        add(2, 0, 1, 0, 0, 0, 4'd3);
        add(4, 0, 1, 0, 0, 0, 4'd4);
        add(1, 0, 1, 0, 0, 0, 4'd5);
        add(12, 0, 1, 0, 0, 0, 4'd5);
        // both directions requesting: strict 26-cycle alternation
        for (int k = 0; k < 2; k++) begin
            add(3, 0, 1, 1, 1, 0, 4'd6);
            add(2, 0, 1, 1, 1, 0, 4'd7);
            add(8, 0, 1, 1, 1, 0, 4'd1);
            add(3, 0, 1, 1, 1, 0, 4'd2);
            add(2, 0, 1, 1, 1, 0, 4'd3);
            add(8, 0, 1, 1, 1, 0, 4'd5);
        end
        // reset during EW_Y with a pending ped request discards it
        add(1, 0, 1, 1, 1, 1, 4'd6);
        add(1, 1, 1, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 1, 0, 4'd0);
        add(8, 0, 1, 0, 1, 0, 4'd1);
        add(3, 0, 1, 0, 1, 0, 4'd2);
        add(2, 0, 1, 0, 1, 0, 4'd3);
        add(1, 0, 1, 0, 1, 0, 4'd5);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            en      = vecs[i].en;
            req_ns  = vecs[i].rns;
            req_ew  = vecs[i].rew;
            ped_req = vecs[i].ped;
            step_chk($sformatf("vec%0d", i), vecs[i].ph);
        end

        // ped press on the NS_CLR exit cycle is served at the EW_CLR exit
        rst = 1'b1; en = 1'b1; req_ns = 1'b0; req_ew = 1'b0; ped_req = 1'b0;
        step_chk("seq_rst", 4'd0);
        rst = 1'b0; req_ew = 1'b1;
        run_until("seq_to_ns_clr", 4'd3, 40);
        step_chk("seq_ns_clr_last", 4'd3);
        ped_req = 1'b1;
        step_chk("seq_clr_exit_press", 4'd5);
        ped_req = 1'b0; req_ew = 1'b0; req_ns = 1'b1;
        run_until("seq_to_ew_clr", 4'd7, 40);
        req_ns = 1'b0;
        step_chk("seq_ew_clr_last", 4'd7);
        step_chk("seq_ped_b_entry", 4'd8);
        // a press during the walk is dropped
        ped_req = 1'b1;
        step_chk("seq_ped_b_press", 4'd8);
        ped_req = 1'b0;
        step_chk("seq_ped_b_2", 4'd8);
        step_chk("seq_ped_b_3", 4'd8);
        step_chk("seq_ped_b_exit", 4'd1);
        for (int k = 0; k < 12; k++) step_chk($sformatf("seq_rest%0d", k), 4'd1);
        // press while en=0 still latches and is acted on once enabled
        en = 1'b0; ped_req = 1'b1;
        step_chk("seq_en0_press", 4'd1);
        en = 1'b1; ped_req = 1'b0;
        step_chk("seq_en0_served", 4'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
